uart_avl_bridge: RTL and testbench

Debug command bridge sitting directly behind the `uart` core's byte streams. It consumes received bytes from the core's `m_axis` output and parses them into read and write commands. It executes each command as a single Avalon-MM master transaction on an 8-bit address control bus, then feeds the reply bytes back into the core's `s_axis` transmit input. This gives host-side register access to DSI controller blocks over the serial link with no CPU.

---
 rtl/uart_avl_bridge_pkg.sv | 32 +++
 rtl/uart_avl_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_uart_avl_bridge.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_avl_bridge_pkg.sv
// Shared types and constants for the UART-to-Avalon debug command bridge.
package uart_avl_bridge_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = DATA_W / 8;
  localparam int unsigned REPLY_BYTES = 5;

  // Reply status bytes
  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_ERR = 8'h45;
  localparam logic [7:0] ACK_UNK = 8'h3F;

  // Default opcodes
  localparam logic [7:0] DEF_CMD_WRITE = 8'h57;
  localparam logic [7:0] DEF_CMD_READ  = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_RD,
    ST_BUS_WR,
    ST_SEND
  } state_t;

  // Map an Avalon response code onto the reply status byte
  function automatic logic [7:0] status_byte(input logic [1:0] resp);
    return (resp == 2'b00) ? ACK_OK : ACK_ERR;
  endfunction

endpackage

// File: rtl/uart_avl_bridge.sv
// Parses read/write commands from the uart rx stream, runs one Avalon-MM
// transaction per command and streams the reply bytes back to the uart tx.
module uart_avl_bridge
  import uart_avl_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  CMD_WRITE      = DEF_CMD_WRITE,
  parameter logic [7:0]  CMD_READ       = DEF_CMD_READ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BE_W-1:0]   avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic [1:0]        avm_response,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              is_rd_q, is_rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        len_q, len_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [7:0]        rply_q [REPLY_BYTES];
  logic [7:0]        rply_d [REPLY_BYTES];

  logic [ADDR_W-1:0] avm_address_d;
  logic              avm_read_d, avm_write_d;
  logic [DATA_W-1:0] avm_writedata_d;
  logic [BE_W-1:0]   avm_byteenable_d;
  logic [7:0]        m_axis_tdata_d;
  logic              m_axis_tvalid_d;
  logic              timeout_err_d;
  logic              accept_c;

  // Rx stream is open only while collecting a command; held low during reset
  assign s_axis_tready = rst_n && (state_q == ST_IDLE || state_q == ST_GET_ADDR ||
                                   state_q == ST_GET_DATA);
  assign accept_c      = s_axis_tvalid && s_axis_tready;
  assign busy          = (state_q != ST_IDLE);

  // Next-state, command capture, bus request and reply sequencing
  always_comb begin
    state_d          = state_q;
    is_rd_d          = is_rd_q;
    cnt_d            = cnt_q;
    idx_d            = idx_q;
    len_d            = len_q;
    timer_d          = timer_q;
    rply_d           = rply_q;
    avm_address_d    = avm_address;
    avm_read_d       = avm_read;
    avm_write_d      = avm_write;
    avm_writedata_d  = avm_writedata;
    avm_byteenable_d = avm_byteenable;
    m_axis_tdata_d   = m_axis_tdata;
    m_axis_tvalid_d  = m_axis_tvalid;
    timeout_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          timer_d = '0;
          if (s_axis_tdata == CMD_WRITE || s_axis_tdata == CMD_READ) begin
            is_rd_d = (s_axis_tdata == CMD_READ);
            state_d = ST_GET_ADDR;
          end else begin
            rply_d[0]       = ACK_UNK;
            len_d           = 3'd1;
            idx_d           = 3'd0;
            m_axis_tdata_d  = ACK_UNK;
            m_axis_tvalid_d = 1'b1;
            state_d         = ST_SEND;
          end
        end
      end

      ST_GET_ADDR: begin
        if (accept_c) begin
          timer_d       = '0;
          avm_address_d = s_axis_tdata;
          if (is_rd_q) begin
            avm_read_d       = 1'b1;
            avm_byteenable_d = '1;
            state_d          = ST_BUS_RD;
          end else begin
            cnt_d   = 2'd0;
            state_d = ST_GET_DATA;
          end
        end else if (timer_q == TMR_LAST) begin
          timer_d       = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_GET_DATA: begin
        if (accept_c) begin
          timer_d                             = '0;
          avm_writedata_d[{cnt_q, 3'b000} +: 8] = s_axis_tdata;
          cnt_d                               = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            avm_write_d      = 1'b1;
            avm_byteenable_d = '1;
            state_d          = ST_BUS_WR;
          end
        end else if (timer_q == TMR_LAST) begin
          timer_d       = '0;
          cnt_d         = 2'd0;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_BUS_RD: begin
        if (!avm_waitrequest) begin
          avm_read_d       = 1'b0;
          avm_byteenable_d = '0;
          rply_d[0]        = status_byte(avm_response);
          rply_d[1]        = avm_readdata[7:0];
          rply_d[2]        = avm_readdata[15:8];
          rply_d[3]        = avm_readdata[23:16];
          rply_d[4]        = avm_readdata[31:24];
          len_d            = 3'd5;
          idx_d            = 3'd0;
          m_axis_tdata_d   = status_byte(avm_response);
          m_axis_tvalid_d  = 1'b1;
          state_d          = ST_SEND;
        end
      end

      ST_BUS_WR: begin
        if (!avm_waitrequest) begin
          avm_write_d      = 1'b0;
          avm_byteenable_d = '0;
          rply_d[0]        = status_byte(avm_response);
          len_d            = 3'd1;
          idx_d            = 3'd0;
          m_axis_tdata_d   = status_byte(avm_response);
          m_axis_tvalid_d  = 1'b1;
          state_d          = ST_SEND;
        end
      end

      ST_SEND: begin
        if (m_axis_tready) begin
          if (idx_q == len_q - 3'd1) begin
            idx_d           = 3'd0;
            m_axis_tdata_d  = 8'h00;
            m_axis_tvalid_d = 1'b0;
            state_d         = ST_IDLE;
          end else begin
            idx_d          = idx_q + 3'd1;
            m_axis_tdata_d = rply_q[idx_d];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      is_rd_q        <= 1'b0;
      cnt_q          <= 2'd0;
      idx_q          <= 3'd0;
      len_q          <= 3'd0;
      timer_q        <= '0;
      for (int i = 0; i < int'(REPLY_BYTES); i++) rply_q[i] <= 8'h00;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      m_axis_tdata   <= 8'h00;
      m_axis_tvalid  <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_rd_q        <= is_rd_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      timer_q        <= timer_d;
      rply_q         <= rply_d;
      avm_address    <= avm_address_d;
      avm_read       <= avm_read_d;
      avm_write      <= avm_write_d;
      avm_writedata  <= avm_writedata_d;
      avm_byteenable <= avm_byteenable_d;
      m_axis_tdata   <= m_axis_tdata_d;
      m_axis_tvalid  <= m_axis_tvalid_d;
      timeout_err    <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_uart_avl_bridge.sv
// Directed bench for uart_avl_bridge with a reply-byte scoreboard and a
// stalling Avalon slave model.
module tb_uart_avl_bridge;
  import uart_avl_bridge_pkg::*;

  localparam int unsigned TMO = 16;

  logic        clk, rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready;
  logic [7:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic [1:0]  avm_response;
  logic        avm_waitrequest;
  logic        busy, timeout_err;

  uart_avl_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_response(avm_response),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Avalon slave: stalls cfg_wait cycles per request, then completes
  int unsigned cfg_wait;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_resp;
  logic [3:0]  stall_cnt;
  logic        req;

  assign req             = avm_read | avm_write;
  assign avm_waitrequest = req && (32'(stall_cnt) < cfg_wait);
  assign avm_readdata    = cfg_rdata;
  assign avm_response    = cfg_resp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   stall_cnt <= 4'd0;
    else if (req) stall_cnt <= avm_waitrequest ? stall_cnt + 4'd1 : 4'd0;
  end

  // Bus observer: records completed transfers and checks request stability
  int          n_rd = 0, n_wr = 0, cur_len = 0, last_len = 0;
  logic [7:0]  last_addr, prev_addr;
  logic [31:0] last_wdata, prev_wdata;
  logic        prev_req = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst_n && req) begin
      if (prev_req) begin
        chk("avm_addr_hold", 32'(avm_address), 32'(prev_addr));
        chk("avm_wdata_hold", avm_writedata, prev_wdata);
      end
      chk("avm_byteenable", 32'(avm_byteenable), 32'hF);
      cur_len++;
      if (!avm_waitrequest) begin
        if (avm_read)  n_rd++;
        if (avm_write) n_wr++;
        last_addr  = avm_address;
        last_wdata = avm_writedata;
        last_len   = cur_len;
        cur_len    = 0;
      end
    end
    if (!rst_n) cur_len = 0;
    prev_req   = rst_n && req && avm_waitrequest;
    prev_addr  = avm_address;
    prev_wdata = avm_writedata;
  end

  // Reply scoreboard
  logic [7:0] exp_q[$];
  int         n_reply = 0, extra = 0, n_tmo = 0;
  logic       rh_stall = 1'b0;
  logic [7:0] rh_data;

  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (rst_n && rh_stall) begin
      chk("tvalid_hold", 32'(m_axis_tvalid), 32'd1);
      chk("tdata_hold", 32'(m_axis_tdata), 32'(rh_data));
    end
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) extra++;
      else begin
        e = exp_q.pop_front();
        chk("reply_byte", 32'(m_axis_tdata), 32'(e));
        n_reply++;
      end
    end
    rh_stall = rst_n && m_axis_tvalid && !m_axis_tready;
    rh_data  = m_axis_tdata;
    if (timeout_err) n_tmo++;
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
    chk("rx_byte_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("drain_to_idle", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {6'b0, avm_read, avm_write, m_axis_tvalid, s_axis_tready, busy, timeout_err,
              avm_address, avm_byteenable, m_axis_tdata}, 32'd0);
    chk({tag, "_wdata"}, avm_writedata, 32'd0);
  endtask

  initial begin
    int base;
    bit hit;
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    bit  hit;
    rst_n = 1'b0; s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    cfg_wait = 0; cfg_rdata = 32'h0; cfg_resp = 2'b00;
    #2;
    chk_reset_outputs("reset_outputs");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_tready", 32'(s_axis_tready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Write, zero stall
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hEF);
    send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_idle();
    chk("wr_count", 32'(n_wr), 32'd1);
    chk("wr_addr", 32'(last_addr), 32'h10);
    chk("wr_data", last_wdata, 32'hDEADBEEF);
    chk("wr_req_len", 32'(last_len), 32'd1);
    chk("wr_no_read", 32'(n_rd), 32'd0);

    // Read, 3-cycle stall
    cfg_wait = 3; cfg_rdata = 32'h12345678;
    exp_q.push_back(8'h4B); exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    send_byte(8'h52); send_byte(8'h24);
    wait_idle();
    chk("rd_count", 32'(n_rd), 32'd1);
    chk("rd_addr", 32'(last_addr), 32'h24);
    chk("rd_req_len", 32'(last_len), 32'd4);

    // Read with error response still returns data
    cfg_wait = 1; cfg_rdata = 32'hCAFEF00D; cfg_resp = 2'b10;
    exp_q.push_back(8'h45); exp_q.push_back(8'h0D); exp_q.push_back(8'hF0);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    send_byte(8'h52); send_byte(8'h33);
    wait_idle();
    chk("rderr_count", 32'(n_rd), 32'd2);
    chk("rderr_addr", 32'(last_addr), 32'h33);

    // Write with error response
    cfg_wait = 0; cfg_resp = 2'b11;
    exp_q.push_back(8'h45);
    send_byte(8'h57); send_byte(8'h44); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_idle();
    chk("wrerr_count", 32'(n_wr), 32'd2);
    chk("wrerr_data", last_wdata, 32'h04030201);

    // Unknown opcode under tx backpressure
    cfg_resp = 2'b00;
    base = n_rd + n_wr;
    m_axis_tready = 1'b0;
    exp_q.push_back(8'h3F);
    send_byte(8'h41);
    repeat (5) @(posedge clk);
    #1;
    chk("unk_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("unk_tdata", 32'(m_axis_tdata), 32'h3F);
    chk("unk_rx_blocked", 32'(s_axis_tready), 32'd0);
    m_axis_tready = 1'b1;
    wait_idle();
    chk("unk_no_bus", 32'(n_rd + n_wr), 32'(base));

    // Inter-byte timeout discards the partial write
    base = n_reply;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hAA);
    repeat (40) @(posedge clk);
    #1;
    chk("tmo_pulses", 32'(n_tmo), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_no_bus", 32'(n_rd + n_wr), 32'd4);
    chk("tmo_no_reply", 32'(n_reply), 32'(base));
    cfg_rdata = 32'h89ABCDEF;
    exp_q.push_back(8'h4B); exp_q.push_back(8'hEF); exp_q.push_back(8'hCD);
    exp_q.push_back(8'hAB); exp_q.push_back(8'h89);
    send_byte(8'h52); send_byte(8'h55);
    wait_idle();
    chk("post_tmo_rd_count", 32'(n_rd), 32'd3);
    chk("post_tmo_rd_addr", 32'(last_addr), 32'h55);

    // Reset while the third reply byte is waiting
    cfg_rdata = 32'h11223344;
    exp_q.push_back(8'h4B); exp_q.push_back(8'h44); exp_q.push_back(8'h33);
    exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    send_byte(8'h52); send_byte(8'h66);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 3) hit = 1'b1;
    end
    m_axis_tready = 1'b0;
    chk("rst_reached_third_byte", 32'(hit), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midsend_reset_outputs");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tready", 32'(s_axis_tready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_reply", 32'(m_axis_tvalid), 32'd0);
    chk("no_extra_replies", 32'(extra), 32'd0);
    chk("tmo_pulses_final", 32'(n_tmo), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
